// File: rtl/eth_pkg.sv
// eth_pkg: shared types and constants for the Ethernet TX/RX path.
// Imported by the framer and the CRC engine.
package eth_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SFD,
    DATA,
    PAD,
    FCS,
    IFG
  } tx_state_e;

  localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
  localparam logic [7:0]  ETH_SFD         = 8'hD5;
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;

  // One reflected CRC-32 step for a single serial bit.
  function automatic logic [31:0] crc32_step(
    input logic [31:0] c,
    input logic        b
  );
    if (c[0] ^ b) return (c >> 1) ^ CRC32_POLY_REFL;
    return c >> 1;
  endfunction

endpackage

// File: rtl/eth_crc32.sv
// eth_crc32: bit-serial reflected CRC-32, LSB-first input.
// Shared by the TX framer and the RX FCS checker.
module eth_crc32
  import eth_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clear,
  input  logic        i_bit_valid,
  input  logic        i_bit_in,
  output logic [31:0] o_crc
);

  logic [31:0] r_crc;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear) begin
      r_crc <= CRC32_INIT;
    end else if (i_bit_valid) begin
      r_crc <= crc32_step(r_crc, i_bit_in);
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/ethernet_tx_framer.sv
// ethernet_tx_framer: buffered 802.3 transmitter with preamble, pad,
// FCS and IFG, driving a Manchester or NRZ serial line.
module ethernet_tx_framer
  import eth_pkg::*;
#(
  parameter int ADDR_W       = 10,
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_PAYLOAD  = 60,
  parameter int IFG_BITS     = 96,
  parameter int MANCHESTER   = 1
) (
  input  logic              tx_clk,
  input  logic              tx_rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W:0]   frame_len,
  input  logic              tx_start,
  output logic              tx_busy,
  output logic              tx_done,
  output logic              len_err,
  output logic              tx_en,
  output logic              tx_out
);

  localparam int LW       = ADDR_W + 1;
  localparam int IFG_CLKS = (MANCHESTER != 0) ? 2 * IFG_BITS : IFG_BITS;
  localparam logic [LW-1:0] MAX_LEN  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [LW-1:0] PRE_LAST = LW'(PREAMBLE_LEN - 1);
  localparam logic [15:0]   IFG_LAST = 16'(IFG_CLKS - 1);
  localparam logic [31:0]   MINP     = MIN_PAYLOAD;

  tx_state_e   r_state;
  logic [7:0]  r_sh;
  logic [2:0]  r_bit;
  logic        r_half;
  logic [LW-1:0] r_cnt;
  logic [LW-1:0] r_len;
  logic [15:0] r_ifg;

  logic [7:0]  r_mem [2**ADDR_W];
  logic [7:0]  r_rd_data;

  logic [LW-1:0]     w_cnt_inc;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [31:0]       w_crc;
  logic w_active;
  logic w_bit_end;
  logic w_byte_end;
  logic w_bit;
  logic w_line;
  logic w_crc_en;
  logic w_len_ok;
  logic w_start_ok;

  assign w_cnt_inc  = r_cnt + LW'(1);
  assign w_active   = (r_state != IDLE) && (r_state != IFG);
  assign w_bit_end  = (MANCHESTER == 0) || r_half;
  assign w_byte_end = w_bit_end && (r_bit == 3'd7);
  assign w_len_ok   = (frame_len != '0) && (frame_len <= MAX_LEN);
  assign w_start_ok = (r_state == IDLE) && tx_start && w_len_ok;
  assign w_crc_en   = w_bit_end && ((r_state == DATA) || (r_state == PAD));

  // FCS bits come straight from the frozen CRC register.
  assign w_bit  = (r_state == FCS) ? ~w_crc[{r_cnt[1:0], r_bit}]
                                   : r_sh[r_bit];
  assign w_line = ((MANCHESTER != 0) && !r_half) ? ~w_bit : w_bit;

  // Prefetch byte k+1 while byte k shifts out; byte 0 during SFD.
  assign w_rd_addr = (r_state == DATA) ? w_cnt_inc[ADDR_W-1:0] : '0;

  always_ff @(posedge tx_clk) begin
    if (wr_en && !tx_busy) begin
      r_mem[wr_addr] <= wr_data;
    end
    r_rd_data <= r_mem[w_rd_addr];
  end

  eth_crc32 u_crc (
    .i_clk       (tx_clk),
    .i_rst_n     (tx_rst_n),
    .i_clear     (w_start_ok),
    .i_bit_valid (w_crc_en),
    .i_bit_in    (r_sh[r_bit]),
    .o_crc       (w_crc)
  );

  always_ff @(posedge tx_clk) begin
    if (!tx_rst_n) begin
      r_state <= IDLE;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
      len_err <= 1'b0;
      tx_en   <= 1'b0;
      tx_out  <= 1'b0;
      r_sh    <= '0;
      r_bit   <= '0;
      r_half  <= 1'b0;
      r_cnt   <= '0;
      r_len   <= '0;
      r_ifg   <= '0;
    end else begin
      len_err <= 1'b0;
      if (w_active) begin
        tx_en  <= 1'b1;
        tx_out <= w_line;
        r_half <= ~w_bit_end;
        if (w_bit_end) begin
          r_bit <= r_bit + 3'd1;
        end
      end
      unique case (r_state)
        IDLE: begin
          if (tx_start) begin
            if (w_len_ok) begin
              r_state <= PREAMBLE;
              tx_busy <= 1'b1;
              r_len   <= frame_len;
              r_sh    <= ETH_PREAMBLE;
              r_cnt   <= '0;
              r_bit   <= '0;
              r_half  <= 1'b0;
            end else begin
              len_err <= 1'b1;
            end
          end
        end
        PREAMBLE: begin
          if (w_byte_end) begin
            if (r_cnt == PRE_LAST) begin
              r_state <= SFD;
              r_sh    <= ETH_SFD;
              r_cnt   <= '0;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
        end
        SFD: begin
          if (w_byte_end) begin
            r_state <= DATA;
            r_sh    <= r_rd_data;
          end
        end
        DATA: begin
          if (w_byte_end) begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc == r_len) begin
              if (32'(r_len) < MINP) begin
                r_state <= PAD;
                r_sh    <= '0;
              end else begin
                r_state <= FCS;
                r_cnt   <= '0;
              end
            end else begin
              r_sh <= r_rd_data;
            end
          end
        end
        PAD: begin
          if (w_byte_end) begin
            if (32'(w_cnt_inc) == MINP) begin
              r_state <= FCS;
              r_cnt   <= '0;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
        end
        FCS: begin
          if (w_byte_end) begin
            if (r_cnt[1:0] == 2'd3) begin
              r_state <= IFG;
              r_ifg   <= '0;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
        end
        IFG: begin
          tx_en  <= 1'b0;
          tx_out <= 1'b0;
          // tx_done marks the last gap clock; busy drops one edge later.
          if (tx_done) begin
            tx_done <= 1'b0;
            tx_busy <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_ifg <= r_ifg + 16'd1;
            if (r_ifg == IFG_LAST) begin
              tx_done <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ethernet_tx_framer.sv
// tb_ethernet_tx_framer: directed checks of the framer in NRZ,
// Manchester and padded configurations.
`timescale 1ns/1ps
module tb_ethernet_tx_framer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [9:0]  wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic [10:0] frame_len = '0;
  logic [2:0]  start = '0;
  logic [2:0]  busy, done, lerr, en, out;

  int vectors = 0;
  int errors  = 0;

  logic [7:0] mdl [0:1023];
  bit         cap [0:16383];
  logic [7:0] rx  [0:1100];
  int cap_n, ifg_cyc, ifg_hi, done_cnt, lead, rx_n, viol;
  bit tmo;

  always #5 clk = ~clk;

  ethernet_tx_framer #(.MIN_PAYLOAD(0), .MANCHESTER(0)) u_nrz (
    .tx_clk(clk), .tx_rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .frame_len(frame_len), .tx_start(start[0]),
    .tx_busy(busy[0]), .tx_done(done[0]), .len_err(lerr[0]),
    .tx_en(en[0]), .tx_out(out[0]));

  ethernet_tx_framer #(.MIN_PAYLOAD(0), .MANCHESTER(1)) u_man (
    .tx_clk(clk), .tx_rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .frame_len(frame_len), .tx_start(start[1]),
    .tx_busy(busy[1]), .tx_done(done[1]), .len_err(lerr[1]),
    .tx_en(en[1]), .tx_out(out[1]));

  ethernet_tx_framer u_def (
    .tx_clk(clk), .tx_rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .frame_len(frame_len), .tx_start(start[2]),
    .tx_busy(busy[2]), .tx_done(done[2]), .len_err(lerr[2]),
    .tx_en(en[2]), .tx_out(out[2]));

  function automatic logic [31:0] crc_model(input int n);
    logic [31:0] c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, mdl[i]};
      for (int k = 0; k < 8; k++)
        c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic logic [7:0] exp_byte(input int j, input int n,
                                          input int tot,
                                          input logic [31:0] fcs);
    if (j < 7) return 8'h55;
    if (j == 7) return 8'hD5;
    if (j < 8 + n) return mdl[j-8];
    if (j < 8 + tot) return 8'h00;
    return fcs[8*(j-8-tot) +: 8];
  endfunction

  task automatic wr(input int a, input logic [7:0] d);
    wr_addr = 10'(a); wr_data = d; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic load(input int n);
    for (int i = 0; i < n; i++) wr(i, mdl[i]);
  endtask

  task automatic start_frame(input int sel, input int len);
    frame_len = 11'(len); start[sel] = 1'b1;
    @(negedge clk);
    start[sel] = 1'b0;
  endtask

  task automatic capture(input int sel, input int budget);
    bit seen = 0;
    cap_n = 0; ifg_cyc = 0; ifg_hi = 0; done_cnt = 0; lead = 0; tmo = 1;
    for (int c = 0; c < budget; c++) begin
      if (en[sel]) begin
        if (cap_n < 16384) cap[cap_n] = out[sel];
        cap_n++; seen = 1;
      end else if (seen && busy[sel]) begin
        ifg_cyc++;
        if (out[sel]) ifg_hi++;
      end else if (!seen) lead++;
      if (done[sel]) done_cnt++;
      if (seen && !busy[sel]) begin tmo = 0; break; end
      @(negedge clk);
    end
  endtask

  task automatic decode(input bit man);
    int nb = man ? 2 : 1;
    viol = 0;
    rx_n = cap_n / (8 * nb);
    if (rx_n > 1101) rx_n = 1101;
    for (int j = 0; j < rx_n; j++)
      for (int k = 0; k < 8; k++) begin
        int idx = (j * 8 + k) * nb;
        if (man && cap[idx] == cap[idx+1]) viol++;
        rx[j][k] = man ? cap[idx+1] : cap[idx];
      end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy, done, lerr, en, out} !== 15'h0) begin
      errors++;
      $display("FAIL reset outputs: got %h want 0", {busy, done, lerr, en, out});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_nrz_crc;
    for (int i = 0; i < 9; i++) mdl[i] = 8'h31 + 8'(i);
    load(9);
    start_frame(0, 9);
    vectors++;
    if ({busy[0], en[0]} !== 2'b10) begin
      errors++; $display("FAIL nrz accept: busy,en=%b want 10", {busy[0], en[0]});
    end
    capture(0, 2000);
    decode(0);
    vectors++; if (tmo !== 0) begin errors++; $display("FAIL nrz timeout: got %0d want 0", tmo); end
    vectors++; if (lead !== 1) begin errors++; $display("FAIL nrz latency: got %0d want 1", lead); end
    vectors++; if (cap_n !== 168) begin errors++; $display("FAIL nrz tx_en: got %0d want 168", cap_n); end
    vectors++; if (ifg_cyc !== 96) begin errors++; $display("FAIL nrz ifg: got %0d want 96", ifg_cyc); end
    vectors++; if (ifg_hi !== 0) begin errors++; $display("FAIL nrz ifg line: got %0d want 0", ifg_hi); end
    vectors++; if (done_cnt !== 1) begin errors++; $display("FAIL nrz done: got %0d want 1", done_cnt); end
    vectors++; if (rx_n !== 21) begin errors++; $display("FAIL nrz bytes: got %0d want 21", rx_n); end
    for (int j = 0; j < rx_n; j++) begin
      vectors++;
      if (rx[j] !== exp_byte(j, 9, 9, 32'hCBF43926)) begin
        errors++;
        $display("FAIL nrz byte %0d: got %h want %h", j, rx[j], exp_byte(j, 9, 9, 32'hCBF43926));
      end
    end
  endtask

  task automatic test_manchester;
    start_frame(1, 9);
    capture(1, 4000);
    decode(1);
    vectors++; if (tmo !== 0) begin errors++; $display("FAIL man timeout: got %0d want 0", tmo); end
    vectors++; if (lead !== 1) begin errors++; $display("FAIL man latency: got %0d want 1", lead); end
    vectors++; if (cap_n !== 336) begin errors++; $display("FAIL man tx_en: got %0d want 336", cap_n); end
    vectors++; if (ifg_cyc !== 192) begin errors++; $display("FAIL man ifg: got %0d want 192", ifg_cyc); end
    vectors++; if (done_cnt !== 1) begin errors++; $display("FAIL man done: got %0d want 1", done_cnt); end
    vectors++; if (viol !== 0) begin errors++; $display("FAIL man pairs: got %0d bad want 0", viol); end
    vectors++; if (rx_n !== 21) begin errors++; $display("FAIL man bytes: got %0d want 21", rx_n); end
    for (int j = 0; j < rx_n; j++) begin
      vectors++;
      if (rx[j] !== exp_byte(j, 9, 9, 32'hCBF43926)) begin
        errors++;
        $display("FAIL man byte %0d: got %h want %h", j, rx[j], exp_byte(j, 9, 9, 32'hCBF43926));
      end
    end
  endtask

  task automatic test_pad;
    logic [31:0] fcs;
    mdl[0] = 8'hAB;
    for (int i = 1; i < 60; i++) mdl[i] = 8'h00;
    fcs = crc_model(60);
    load(1);
    start_frame(2, 1);
    capture(2, 4000);
    decode(1);
    vectors++; if (cap_n !== 1152) begin errors++; $display("FAIL pad tx_en: got %0d want 1152", cap_n); end
    vectors++; if (ifg_cyc !== 192) begin errors++; $display("FAIL pad ifg: got %0d want 192", ifg_cyc); end
    vectors++; if (done_cnt !== 1) begin errors++; $display("FAIL pad done: got %0d want 1", done_cnt); end
    vectors++; if (rx_n !== 72) begin errors++; $display("FAIL pad bytes: got %0d want 72", rx_n); end
    for (int j = 0; j < rx_n; j++) begin
      vectors++;
      if (rx[j] !== exp_byte(j, 1, 60, fcs)) begin
        errors++;
        $display("FAIL pad byte %0d: got %h want %h", j, rx[j], exp_byte(j, 1, 60, fcs));
      end
    end
  endtask

  task automatic test_full_buffer;
    logic [31:0] fcs;
    for (int i = 0; i < 1024; i++) mdl[i] = 8'((i * 37) ^ (i >> 2));
    fcs = crc_model(1024);
    load(1024);
    start_frame(0, 1024);
    capture(0, 10000);
    decode(0);
    vectors++; if (cap_n !== 8288) begin errors++; $display("FAIL full tx_en: got %0d want 8288", cap_n); end
    vectors++; if (rx_n !== 1036) begin errors++; $display("FAIL full bytes: got %0d want 1036", rx_n); end
    for (int j = 0; j < rx_n; j++) begin
      vectors++;
      if (rx[j] !== exp_byte(j, 1024, 1024, fcs)) begin
        errors++;
        $display("FAIL full byte %0d: got %h want %h", j, rx[j], exp_byte(j, 1024, 1024, fcs));
      end
    end
  endtask

  task automatic test_len_err;
    int lens [2] = '{0, 1025};
    for (int t = 0; t < 2; t++) begin
      int hits = 0;
      start_frame(0, lens[t]);
      vectors++;
      if ({lerr[0], busy[0]} !== 2'b10) begin
        errors++; $display("FAIL len_err %0d pulse: lerr,busy=%b want 10", lens[t], {lerr[0], busy[0]});
      end
      @(negedge clk);
      vectors++;
      if (lerr[0] !== 1'b0) begin
        errors++; $display("FAIL len_err %0d width: got %b want 0", lens[t], lerr[0]);
      end
      for (int c = 0; c < 20; c++) begin
        if (busy[0] || en[0]) hits++;
        @(negedge clk);
      end
      vectors++;
      if (hits !== 0) begin
        errors++; $display("FAIL len_err %0d idle: got %0d active cycles want 0", lens[t], hits);
      end
    end
  endtask

  task automatic test_busy_ignore;
    int hits = 0;
    for (int i = 0; i < 9; i++) mdl[i] = 8'h31 + 8'(i);
    load(9);
    start_frame(0, 9);
    fork
      capture(0, 2000);
      begin
        repeat (3) @(negedge clk);
        wr_addr = '0; wr_data = 8'hFF; wr_en = 1'b1; start[0] = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        for (int c = 0; c < 2000 && !done[0]; c++) @(negedge clk);
        @(negedge clk);
        start[0] = 1'b0;
      end
    join
    decode(0);
    vectors++; if (cap_n !== 168) begin errors++; $display("FAIL busy tx_en: got %0d want 168", cap_n); end
    vectors++; if (done_cnt !== 1) begin errors++; $display("FAIL busy done: got %0d want 1", done_cnt); end
    for (int j = 0; j < rx_n; j++) begin
      vectors++;
      if (rx[j] !== exp_byte(j, 9, 9, 32'hCBF43926)) begin
        errors++;
        $display("FAIL busy byte %0d: got %h want %h", j, rx[j], exp_byte(j, 9, 9, 32'hCBF43926));
      end
    end
    for (int c = 0; c < 20; c++) begin
      if (busy[0] || en[0]) hits++;
      @(negedge clk);
    end
    vectors++;
    if (hits !== 0) begin errors++; $display("FAIL busy queued: got %0d active cycles want 0", hits); end
  endtask

  task automatic test_same_cycle_write;
    logic [31:0] fcs;
    mdl[0] = 8'h41;
    fcs = crc_model(9);
    wr_addr = '0; wr_data = 8'h41; wr_en = 1'b1;
    frame_len = 11'd9; start[0] = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; start[0] = 1'b0;
    capture(0, 2000);
    decode(0);
    vectors++; if (rx_n !== 21) begin errors++; $display("FAIL samecyc bytes: got %0d want 21", rx_n); end
    for (int j = 0; j < rx_n; j++) begin
      vectors++;
      if (rx[j] !== exp_byte(j, 9, 9, fcs)) begin
        errors++;
        $display("FAIL samecyc byte %0d: got %h want %h", j, rx[j], exp_byte(j, 9, 9, fcs));
      end
    end
  endtask

  task automatic test_reset_mid;
    int hits = 0;
    mdl[0] = 8'h31;
    wr(0, 8'h31);
    start_frame(0, 9);
    repeat (100) @(negedge clk);
    vectors++;
    if (en[0] !== 1'b1) begin errors++; $display("FAIL midrst pre: tx_en=%b want 1", en[0]); end
    rst_n = 1'b0;
    @(negedge clk);
    vectors++;
    if ({busy[0], done[0], lerr[0], en[0], out[0]} !== 5'b0) begin
      errors++;
      $display("FAIL midrst outputs: got %b want 00000", {busy[0], done[0], lerr[0], en[0], out[0]});
    end
    rst_n = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (done[0] || en[0] || busy[0]) hits++;
    end
    vectors++;
    if (hits !== 0) begin errors++; $display("FAIL midrst quiet: got %0d active cycles want 0", hits); end
    start_frame(0, 9);
    capture(0, 2000);
    decode(0);
    vectors++; if (cap_n !== 168) begin errors++; $display("FAIL midrst tx_en: got %0d want 168", cap_n); end
    vectors++; if (done_cnt !== 1) begin errors++; $display("FAIL midrst done: got %0d want 1", done_cnt); end
    for (int j = 0; j < rx_n; j++) begin
      vectors++;
      if (rx[j] !== exp_byte(j, 9, 9, 32'hCBF43926)) begin
        errors++;
        $display("FAIL midrst byte %0d: got %h want %h", j, rx[j], exp_byte(j, 9, 9, 32'hCBF43926));
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_nrz_crc();
    test_manchester();
    test_pad();
    test_full_buffer();
    test_len_err();
    test_busy_ignore();
    test_same_cycle_write();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
